// File: rtl/approx_error_monitor.sv
// Exhaustive error monitor for an approximate 2-bit adder.
// Sweeps all 16 operand pairs and accumulates absolute-error statistics.
module approx_error_monitor #(
  parameter int ET = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] dut_in,
  input  logic [2:0] dut_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] max_err,
  output logic [4:0] err_cnt,
  output logic [6:0] sum_err,
  output logic       viol
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       drv_valid;
  logic       s1_valid;
  logic [3:0] s1_vec;
  logic [2:0] s1_out;
  logic       accept;

  logic [1:0] op_a;
  logic [1:0] op_b;
  logic [2:0] exact;
  logic [2:0] err;
  logic [2:0] max_nx;

  assign accept = (state == IDLE) && start;
  assign done   = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SWEEP;
      SWEEP: if (cnt == 4'd15) state_nx = DRAIN;
      DRAIN: if (cnt == 4'd1) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cnt indexes vectors in SWEEP and drain cycles in DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dut_in    <= '0;
      drv_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      dut_in    <= (state == SWEEP) ? cnt : 4'd0;
      drv_valid <= (state == SWEEP);
      busy      <= (state == SWEEP) ||
                   ((state == DRAIN) && (cnt == 4'd0));
      if (state_nx != state)
        cnt <= '0;
      else if ((state == SWEEP) || (state == DRAIN))
        cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
      s1_out   <= '0;
    end else begin
      s1_valid <= drv_valid;
      s1_vec   <= dut_in;
      s1_out   <= dut_out;
    end
  end

  assign op_a   = s1_vec[1:0];
  assign op_b   = s1_vec[3:2];
  assign exact  = {1'b0, op_a} + {1'b0, op_b};
  assign err    = (s1_out >= exact) ? (s1_out - exact)
                                    : (exact - s1_out);
  assign max_nx = (err > max_err) ? err : max_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err <= '0;
      err_cnt <= '0;
      sum_err <= '0;
      viol    <= 1'b0;
    end else if (accept) begin
      max_err <= '0;
      err_cnt <= '0;
      sum_err <= '0;
      viol    <= 1'b0;
    end else if (s1_valid) begin
      max_err <= max_nx;
      err_cnt <= err_cnt + 5'(err != 3'd0);
      sum_err <= sum_err + 7'(err);
      viol    <= ({1'b0, max_nx} > 4'(ET));
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: three instances (ET=7,5,6) in lockstep,
// a timeline/statistics model checked every cycle, plus literal checks.
module tb_approx_error_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  int   mode = 0;

  logic [3:0] din7, din5, din6;
  logic [2:0] out7, out5, out6;
  logic       busy7, busy5, busy6;
  logic       done7, done5, done6;
  logic [2:0] mx7, mx5, mx6;
  logic [4:0] ec7, ec5, ec6;
  logic [6:0] se7, se5, se6;
  logic       v7, v5, v6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0 exact, 1 stuck at 0, 2 stuck at 7, 3 exact+1 on vector 9
  function automatic logic [2:0] adder(input int m, input logic [3:0] v);
    int s;
    s = int'(v[1:0]) + int'(v[3:2]);
    case (m)
      1: return 3'd0;
      2: return 3'd7;
      3: return (v == 4'd9) ? 3'(s + 1) : 3'(s);
      default: return 3'(s);
    endcase
  endfunction

  assign out7 = adder(mode, din7);
  assign out5 = adder(mode, din5);
  assign out6 = adder(mode, din6);

  approx_error_monitor #(.ET(7)) u7 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(din7),
    .dut_out(out7), .busy(busy7), .done(done7), .max_err(mx7),
    .err_cnt(ec7), .sum_err(se7), .viol(v7));
  approx_error_monitor #(.ET(5)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(din5),
    .dut_out(out5), .busy(busy5), .done(done5), .max_err(mx5),
    .err_cnt(ec5), .sum_err(se5), .viol(v5));
  approx_error_monitor #(.ET(6)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(din6),
    .dut_out(out6), .busy(busy6), .done(done6), .max_err(mx6),
    .err_cnt(ec6), .sum_err(se6), .viol(v6));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void stats(input int m, output int mx,
                                output int cnt, output int sum);
    mx = 0; cnt = 0; sum = 0;
    for (int v = 0; v < 16; v++) begin
      int ex, o, e;
      ex = (v % 4) + (v / 4);
      o  = int'(adder(m, 4'(v)));
      e  = (o > ex) ? o - ex : ex - o;
      if (e > mx) mx = e;
      if (e != 0) cnt++;
      sum += e;
    end
  endfunction

  // p = cycles since the accept edge; sweep is active while act is set
  bit act = 1'b0;
  int p = 0;
  int emax = 0, ecnt = 0, esum = 0;
  int mode_r = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 1'b0; p = 0;
      emax = 0; ecnt = 0; esum = 0;
    end else if ((!act || p >= 19) && start) begin
      act = 1'b1; p = 0; mode_r = mode;
    end else if (act) begin
      p++;
      if (p == 18) stats(mode_r, emax, ecnt, esum);
    end
  end

  task automatic check_inst(input string nm, input int et,
                            input logic [3:0] di, input logic b,
                            input logic d, input logic [2:0] mx,
                            input logic [4:0] ec, input logic [6:0] se,
                            input logic v);
    chk({nm, "_dut_in"}, int'(di), (act && p >= 1 && p <= 16) ? p - 1 : 0);
    chk({nm, "_busy"}, int'(b), int'(act && p >= 1 && p <= 17));
    chk({nm, "_done"}, int'(d), int'(act && p == 18));
    if (!act || p >= 18) begin
      chk({nm, "_max_err"}, int'(mx), emax);
      chk({nm, "_err_cnt"}, int'(ec), ecnt);
      chk({nm, "_sum_err"}, int'(se), esum);
      chk({nm, "_viol"}, int'(v), int'(emax > et));
    end
  endtask

  always @(negedge clk) begin
    check_inst("u7", 7, din7, busy7, done7, mx7, ec7, se7, v7);
    check_inst("u5", 5, din5, busy5, done5, mx5, ec5, se5, v5);
    check_inst("u6", 6, din6, busy6, done6, mx6, ec6, se6, v6);
  end

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done7 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(done7), 1);
  endtask

  task automatic lit(input string nm, input int mx, input int ec,
                     input int se);
    chk({nm, "_lit_max"}, int'(mx7), mx);
    chk({nm, "_lit_cnt"}, int'(ec7), ec);
    chk({nm, "_lit_sum"}, int'(se7), se);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy7), 0);

    mode = 0;
    pulse_start();
    wait_done(n);
    chk("exact_latency", n, 18);
    lit("exact", 0, 0, 0);
    chk("exact_viol", int'(v7), 0);
    repeat (3) @(negedge clk);

    mode = 1;
    pulse_start();
    wait_done(n);
    lit("stuck0", 6, 15, 48);
    chk("stuck0_viol7", int'(v7), 0);
    chk("stuck0_viol5", int'(v5), 1);
    repeat (3) @(negedge clk);

    mode = 2;
    pulse_start();
    wait_done(n);
    lit("stuck7", 7, 16, 64);
    chk("stuck7_viol6", int'(v6), 1);
    repeat (3) @(negedge clk);

    mode = 3;
    pulse_start();
    wait_done(n);
    lit("plus1", 1, 1, 1);
    repeat (3) @(negedge clk);

    mode = 1;
    pulse_start();
    repeat (9) @(negedge clk);
    chk("rst_probe_vec8", int'(din7), 8);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dut_in", int'(din7), 0);
    chk("rst_busy", int'(busy7), 0);
    chk("rst_done", int'(done7), 0);
    lit("rst", 0, 0, 0);
    chk("rst_viol", int'(v5), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done7 || busy7) n++;
    end
    chk("rst_no_sweep", n, 0);
    pulse_start();
    wait_done(n);
    lit("after_rst", 6, 15, 48);
    repeat (3) @(negedge clk);

    mode = 2;
    pulse_start();
    repeat (5) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done(n);
    lit("restart", 7, 16, 64);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("done_start_ignored", int'(busy7), 0);
    lit("hold", 7, 16, 64);

    mode = 0;
    @(negedge clk); #1 start = 1'b1;
    wait_done(n);
    @(negedge clk);
    wait_done(n);
    chk("b2b_period", n + 1, 20);
    @(negedge clk);
    wait_done(n);
    chk("b2b_period2", n + 1, 20);
    lit("b2b", 0, 0, 0);
    #1 start = 1'b0;
    repeat (25) @(negedge clk);
    chk("b2b_stopped", int'(busy7), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_error_monitor.md
APPROX_ERROR_MONITOR -- requirements
Module: approx_error_monitor

Interface
REQ-001 The block SHALL have parameter ET, default 7, giving the maximum allowed absolute error (0..7).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: sweep request, sampled in IDLE only.
REQ-005 The block SHALL have port dut_in, output, 4 bits: stimulus to the approximate 2-bit adder. Bits [1:0] are operand A and bits [3:2] are operand B; dut_in[0] drives in0 through dut_in[3], which drives in3.
REQ-006 The block SHALL have port dut_out, input, 3 bits: adder result returned combinationally, with dut_out[0] = out0.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a sweep or drain is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port max_err, output, 3 bits: maximum absolute error over the sweep.
REQ-010 The block SHALL have port err_cnt, output, 5 bits: number of vectors with nonzero error (0..16).
REQ-011 The block SHALL have port sum_err, output, 7 bits: sum of absolute errors (0..112).
REQ-012 The block SHALL have port viol, output, 1 bit: high when max_err > ET.

Function
REQ-013 The FSM SHALL have the states IDLE, SWEEP, DRAIN and DONE; the encoding is free.
REQ-014 In IDLE with start=1 at edge E, the block SHALL enter SWEEP and clear max_err, err_cnt, sum_err and viol at edge E.
REQ-015 In SWEEP, dut_in SHALL take the values 0,1,…,15 at edges E+1…E+16, one vector per cycle in ascending order with no gaps.
REQ-016 After the vector-15 cycle, the FSM SHALL enter DRAIN for 2 cycles, then DONE for 1 cycle, then IDLE.
REQ-017 Stage 1 SHALL register dut_out and the matching vector at the edge after that vector is driven.
REQ-018 Stage 2 SHALL compute exact = A+B (3-bit, no overflow) and err = |dut_out_reg − exact| (3-bit, unsigned compare before subtract), and SHALL accumulate at the next edge.
REQ-019 The accumulation update SHALL be: max_err = max(max_err, err); err_cnt += (err≠0); sum_err += err; viol = (new max_err > ET).
REQ-020 The last accumulation SHALL occur at edge E+18; done SHALL be high for exactly the cycle from E+18 to E+19.
REQ-021 busy SHALL be high from edge E+1 to edge E+18, falling in the same cycle that done rises.
REQ-022 start SHALL be ignored while not in IDLE, including when asserted on the DONE cycle; no request SHALL be queued.
REQ-023 Results SHALL hold stable after done until the next accepted start.
REQ-024 dut_in SHALL read 0 in IDLE, DRAIN and DONE.
REQ-025 Accumulators SHALL NOT wrap; the widths above cover the full 16-vector worst case.
REQ-026 A start held high continuously SHALL launch back-to-back sweeps, each accepted in IDLE one cycle after DONE.

Reset
REQ-027 On rst_n=0, at any time including mid-sweep, the block SHALL immediately force state=IDLE, dut_in=0, busy=0, done=0, max_err=0, err_cnt=0, sum_err=0, viol=0 and clear pipeline valids.
REQ-028 After rst_n rises, no sweep SHALL begin without a fresh start sampled in IDLE.

Verification
REQ-029 Exact DUT model (dut_out=A+B), start pulse -> done exactly 18 edges after the accept edge; max_err=0, err_cnt=0, sum_err=0, viol=0.
REQ-030 DUT output stuck at 0 with ET=7 -> max_err=6, err_cnt=15, sum_err=48, viol=0; rerun with ET=5 -> viol=1.
REQ-031 DUT output stuck at 7 -> max_err=7, err_cnt=16, sum_err=64, viol=1 with ET=6.
REQ-032 DUT returns exact+1 only for vector 9 (A=1, B=2, giving 4) -> max_err=1, err_cnt=1, sum_err=1; a probe SHALL confirm dut_in sequence 0..15 on consecutive cycles.
REQ-033 rst_n pulsed low at vector 8 -> all outputs 0 asynchronously, no done; a following start gives a correct full sweep.
REQ-034 start re-asserted during SWEEP and on the DONE cycle -> no extra sweep and no result corruption; start held high -> sweeps repeat with a period of 20 cycles.
